// File: rtl/rf_ex_interlock.sv
// RF->EX->MEM tag pipeline with load-use interlock.
// Bubbles EX and holds IF/RF while an operand waits on a load.
module rf_ex_interlock #(
  parameter logic [31:0] NOP_INST       = 32'h83FF_F800,
  parameter bit          MEM_LOAD_STALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_rf,
  input  logic [31:0] pc_rf,
  input  logic [31:0] a_rf,
  input  logic [31:0] b_rf,
  input  logic [31:0] d_rf,
  input  logic        ra_used,
  input  logic        rb_used,
  input  logic        rc_used,
  input  logic        rc_writes,
  input  logic        flush,
  input  logic        mem_stall,
  output logic        stall_rf,
  output logic [31:0] inst_ex,
  output logic [31:0] pc_ex,
  output logic [31:0] a_ex,
  output logic [31:0] b_ex,
  output logic [31:0] d_ex,
  output logic [4:0]  rc_ex,
  output logic [4:0]  rc_mem,
  output logic        op_br_or_jmp_ex,
  output logic        op_br_or_jmp_mem,
  output logic        ld_ex,
  output logic        ld_mem
);

  localparam logic [4:0] R31 = 5'd31;

  logic [5:0] op_rf;
  logic [4:0] rc_rf;
  logic [4:0] ra_rf;
  logic [4:0] rb_rf;
  logic       ld_rf;
  logic       br_rf;
  logic       hazard_ex;
  logic       hazard_mem;
  logic       hazard;

  assign op_rf = inst_rf[31:26];
  assign rc_rf = inst_rf[25:21];
  assign ra_rf = inst_rf[20:16];
  assign rb_rf = inst_rf[15:11];

  // Decode load and control-transfer classes of the RF instruction
  always_comb begin
    ld_rf = (op_rf == 6'h18) | (op_rf == 6'h1F);
    br_rf = (op_rf == 6'h1B) | (op_rf == 6'h1C) |
            (op_rf == 6'h1D);
  end

  // Operand dependence on a load still in EX or MEM; R31 never matches
  always_comb begin
    hazard_ex = ld_ex & (rc_ex != R31) &
                ((ra_used & (ra_rf == rc_ex)) |
                 (rb_used & (rb_rf == rc_ex)) |
                 (rc_used & (rc_rf == rc_ex)));
    hazard_mem = MEM_LOAD_STALL & ld_mem &
                 (rc_mem != R31) &
                 ((ra_used & (ra_rf == rc_mem)) |
                  (rb_used & (rb_rf == rc_mem)) |
                  (rc_used & (rc_rf == rc_mem)));
    hazard = hazard_ex | hazard_mem;
  end

  // A flushed RF instruction is discarded, so it never needs holding
  assign stall_rf = mem_stall | (hazard & ~flush);

  // EX stage: take RF, insert a bubble, or hold on a memory stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_ex         <= NOP_INST;
      pc_ex           <= '0;
      a_ex            <= '0;
      b_ex            <= '0;
      d_ex            <= '0;
      rc_ex           <= R31;
      ld_ex           <= 1'b0;
      op_br_or_jmp_ex <= 1'b0;
    end else if (!mem_stall) begin
      if (flush | hazard) begin
        inst_ex         <= NOP_INST;
        pc_ex           <= '0;
        a_ex            <= '0;
        b_ex            <= '0;
        d_ex            <= '0;
        rc_ex           <= R31;
        ld_ex           <= 1'b0;
        op_br_or_jmp_ex <= 1'b0;
      end else begin
        inst_ex         <= inst_rf;
        pc_ex           <= pc_rf;
        a_ex            <= a_rf;
        b_ex            <= b_rf;
        d_ex            <= d_rf;
        rc_ex           <= rc_writes ? rc_rf : R31;
        ld_ex           <= ld_rf;
        op_br_or_jmp_ex <= br_rf;
      end
    end
  end

  // MEM tags follow EX unless the data memory is busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rc_mem           <= R31;
      ld_mem           <= 1'b0;
      op_br_or_jmp_mem <= 1'b0;
    end else if (!mem_stall) begin
      rc_mem           <= rc_ex;
      ld_mem           <= ld_ex;
      op_br_or_jmp_mem <= op_br_or_jmp_ex;
    end
  end

endmodule
